// File: rtl/turbo_out_pkg.sv
// Shared constants and grant encoding for the turbo encoder output bit buffer scheduler.
package turbo_out_pkg;

   localparam int unsigned DEPTH_DFLT = 16;
   localparam int unsigned AW_DFLT    = 4;
   localparam int unsigned SYM_W_DFLT = 4;

   // Bit positions inside an encoder symbol.
   localparam int unsigned X  = 0;
   localparam int unsigned Z  = 1;
   localparam int unsigned ZP = 2;
   localparam int unsigned XP = 3;

   typedef enum logic [1:0] {
      G_IDLE,
      G_WR,
      G_RD
   } gnt_e;

endpackage

// File: rtl/turbo_sym_stager.sv
// Holds one accepted encoder symbol and presents its bits one at a time, x first.
module turbo_sym_stager
   import turbo_out_pkg::*;
#(
   parameter int unsigned SYM_W = SYM_W_DFLT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             load_i,
   input  logic [SYM_W-1:0] sym_i,
   input  logic             mode_i,
   input  logic             adv_i,
   output logic             busy_o,
   output logic             next_bit_o
);

   logic [SYM_W-1:0] sym_q, sym_d;
   logic             mode_q, mode_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [1:0]       last_idx;

   always_comb begin
      sym_d    = sym_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      last_idx = mode_q ? 2'(XP) : 2'(ZP);
      if (flush_i) begin
         sym_d  = '0;
         mode_d = 1'b0;
         cnt_d  = '0;
         busy_d = 1'b0;
      end else if (load_i) begin
         sym_d  = sym_i;
         mode_d = mode_i;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (adv_i && busy_q) begin
         if (cnt_q == last_idx) begin
            cnt_d  = '0;
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sym_q  <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         sym_q  <= sym_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o     = busy_q;
   assign next_bit_o = sym_q[cnt_q];

endmodule

// File: rtl/turbo_out_buf_sched.sv
// Circular-FIFO access scheduler for the 16-bit output SRAM: single-bit writes from the
// symbol stager, two-bit reads for the serializer, one SRAM operation per cycle.
module turbo_out_buf_sched
   import turbo_out_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DFLT,
   parameter int unsigned AW    = AW_DFLT,
   parameter int unsigned SYM_W = SYM_W_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             mode,
   input  logic [SYM_W-1:0] sym_in,
   input  logic             sym_valid,
   output logic             sym_ready,
   input  logic             rd_req,
   output logic             out0,
   output logic             out1,
   output logic             validOut,
   output logic [AW:0]      level,
   output logic [AW-1:0]    addr1,
   output logic [AW-1:0]    addr2,
   output logic             WriteLine,
   output logic             RdWr,
   output logic             DevEn,
   input  logic             readLine1,
   input  logic             readLine2
);

   localparam logic [AW:0]   LvlOne    = (AW+1)'(1);
   localparam logic [AW:0]   LvlTwo    = (AW+1)'(2);
   localparam logic [AW:0]   LvlAccMax = (AW+1)'(DEPTH - 4);
   localparam logic [AW-1:0] PtrOne    = AW'(1);
   localparam logic [AW-1:0] PtrTwo    = AW'(2);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          rd_pend_q, rd_pend_d;
   logic          out0_q, out0_d, out1_q, out1_d;
   logic          valid_q, valid_d;
   gnt_e          last_gnt_q, gnt;

   logic          busy, next_bit, accept, rd_elig;

   // Room for a worst-case termination symbol is required before accepting.
   assign sym_ready = !reset && !flush && !busy && (level_q <= LvlAccMax);
   assign accept    = sym_valid && sym_ready;
   assign rd_elig   = rd_pend_q && (level_q >= LvlTwo);

   turbo_sym_stager #(
      .SYM_W (SYM_W)
   ) u_stager (
      .clk_i      (clk),
      .rst_i      (reset),
      .flush_i    (flush),
      .load_i     (accept),
      .sym_i      (sym_in),
      .mode_i     (mode),
      .adv_i      (gnt == G_WR),
      .busy_o     (busy),
      .next_bit_o (next_bit)
   );

   // Read wins unless it won last cycle while a write is waiting.
   always_comb begin
      gnt = G_IDLE;
      if (!flush) begin
         if (rd_elig && (!busy || last_gnt_q != G_RD)) begin
            gnt = G_RD;
         end else if (busy) begin
            gnt = G_WR;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt_q <= G_IDLE;
      end else begin
         last_gnt_q <= gnt;
      end
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      rd_pend_d = rd_pend_q;
      out0_d    = out0_q;
      out1_d    = out1_q;
      valid_d   = 1'b0;
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         rd_pend_d = 1'b0;
      end else begin
         if (rd_req && !rd_pend_q) begin
            rd_pend_d = 1'b1;
         end
         case (gnt)
            G_WR: begin
               wr_ptr_d = wr_ptr_q + PtrOne;
               level_d  = level_q + LvlOne;
            end
            G_RD: begin
               rd_ptr_d  = rd_ptr_q + PtrTwo;
               level_d   = level_q - LvlTwo;
               rd_pend_d = 1'b0;
               out0_d    = readLine1;
               out1_d    = readLine2;
               valid_d   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         rd_pend_q <= 1'b0;
         out0_q    <= 1'b0;
         out1_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         rd_pend_q <= rd_pend_d;
         out0_q    <= out0_d;
         out1_q    <= out1_d;
         valid_q   <= valid_d;
      end
   end

   // SRAM samples on the falling edge, so these are driven for the whole granted cycle.
   always_comb begin
      addr1     = '0;
      addr2     = '0;
      WriteLine = 1'b0;
      RdWr      = 1'b0;
      DevEn     = 1'b1;
      case (gnt)
         G_WR: begin
            addr1     = wr_ptr_q;
            WriteLine = next_bit;
            RdWr      = 1'b1;
            DevEn     = 1'b0;
         end
         G_RD: begin
            addr1 = rd_ptr_q;
            addr2 = rd_ptr_q + PtrOne;
            DevEn = 1'b0;
         end
         default: ;
      endcase
   end

   assign out0     = out0_q;
   assign out1     = out1_q;
   assign validOut = valid_q;
   assign level    = level_q;

endmodule

// File: tb/tb_turbo_out_buf_sched.sv
// Directed bench for turbo_out_buf_sched with a falling-edge SRAM model and access logs.
module tb_turbo_out_buf_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] sym_in = 4'd0;
   logic       sym_valid = 1'b0;
   logic       rd_req = 1'b0;
   logic       sym_ready, out0, out1, validOut, WriteLine, RdWr, DevEn;
   logic [4:0] level;
   logic [3:0] addr1, addr2;
   logic       readLine1 = 1'b0;
   logic       readLine2 = 1'b0;
   logic [15:0] mem = '0;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] wq[$];
   logic [7:0] rq[$];
   logic [1:0] gq[$];

   always #5 clk = ~clk;

   turbo_out_buf_sched dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .mode      (mode),
      .sym_in    (sym_in),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .rd_req    (rd_req),
      .out0      (out0),
      .out1      (out1),
      .validOut  (validOut),
      .level     (level),
      .addr1     (addr1),
      .addr2     (addr2),
      .WriteLine (WriteLine),
      .RdWr      (RdWr),
      .DevEn     (DevEn),
      .readLine1 (readLine1),
      .readLine2 (readLine2)
   );

   // SRAM model plus per-cycle grant log: 0 idle, 1 write, 2 read.
   always @(negedge clk) begin
      if (!DevEn) begin
         if (RdWr) begin
            mem[addr1] <= WriteLine;
            wq.push_back({addr1, 3'b000, WriteLine});
         end else begin
            readLine1 <= mem[addr1];
            readLine2 <= mem[addr2];
            rq.push_back({addr1, addr2});
         end
      end
      gq.push_back(DevEn ? 2'd0 : (RdWr ? 2'd1 : 2'd2));
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sym(input logic [3:0] s, input logic m);
      int w;
      w = 0;
      while (!sym_ready && w < 40) begin
         tick();
         w++;
      end
      check_eq("send_ready", sym_ready, 1);
      sym_in    = s;
      mode      = m;
      sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic e0, input logic e1);
      int lat;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      lat = 1;
      while (!validOut && lat < 20) begin
         tick();
         lat++;
      end
      check_eq({tag, "_valid"}, validOut, 1);
      check_eq({tag, "_lat_ge2"}, (lat >= 2) ? 1 : 0, 1);
      check_eq({tag, "_pair"}, {out0, out1}, {e0, e1});
      tick();
      check_eq({tag, "_pulse_end"}, validOut, 0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("flush_level", level, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // 1: reset values, then reset in the middle of a termination symbol
      #2;
      check_eq("rst_sym_ready", sym_ready, 0);
      check_eq("rst_outs", {out0, out1, validOut}, 3'b000);
      check_eq("rst_level", level, 0);
      check_eq("rst_sram", {addr1, addr2, WriteLine, RdWr, DevEn}, {4'd0, 4'd0, 3'b001});
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_eq("rel_sym_ready", sym_ready, 1);
      send_sym(4'b1011, 1'b1);
      tick();
      check_eq("t1_second_wr", {addr1, RdWr, DevEn}, {4'd1, 2'b10});
      reset = 1'b1;
      #1;
      check_eq("t1_rst_level", level, 0);
      check_eq("t1_rst_sram", {addr1, addr2, WriteLine, RdWr, DevEn}, {4'd0, 4'd0, 3'b001});
      check_eq("t1_rst_outs", {out0, out1, validOut, sym_ready}, 4'b0000);
      tick();
      reset = 1'b0;
      tick();
      check_eq("t1_ready_after", sym_ready, 1);
      check_eq("t1_no_partial", {level, DevEn}, {5'd0, 1'b1});

      // 2: normal symbol 0110 then one read
      wq.delete();
      rq.delete();
      send_sym(4'b0110, 1'b0);
      repeat (5) tick();
      check_eq("t2_nwr", wq.size(), 3);
      check_eq("t2_wr0", wq[0], 8'h00);
      check_eq("t2_wr1", wq[1], 8'h11);
      check_eq("t2_wr2", wq[2], 8'h21);
      check_eq("t2_level", level, 3);
      do_read("t2_rd", 1'b0, 1'b1);
      check_eq("t2_rd_addr", rq[0], 8'h01);
      check_eq("t2_level_after", level, 1);

      // 3: termination symbol 1011, two reads
      do_flush();
      wq.delete();
      send_sym(4'b1011, 1'b1);
      repeat (5) tick();
      check_eq("t3_nwr", wq.size(), 4);
      check_eq("t3_wdata", {wq[0][0], wq[1][0], wq[2][0], wq[3][0]}, 4'b1101);
      check_eq("t3_waddr", {wq[0][7:4], wq[3][7:4]}, 8'h03);
      check_eq("t3_level", level, 4);
      do_read("t3_rd0", 1'b1, 1'b1);
      do_read("t3_rd1", 1'b0, 1'b1);
      check_eq("t3_level_after", level, 0);

      // 4: fill to full, back-pressure release needs two reads
      send_sym(4'b0101, 1'b1);
      send_sym(4'b0011, 1'b1);
      send_sym(4'b1100, 1'b1);
      send_sym(4'b1001, 1'b1);
      repeat (5) tick();
      check_eq("t4_full_level", level, 16);
      check_eq("t4_full_ready", sym_ready, 0);
      do_read("t4_rd0", 1'b1, 1'b0);
      check_eq("t4_level14", level, 14);
      check_eq("t4_ready14", sym_ready, 0);
      do_read("t4_rd1", 1'b1, 1'b0);
      check_eq("t4_level12", level, 12);
      check_eq("t4_ready12", sym_ready, 1);

      // 5: read pointer wraps 14 -> 0
      do_read("t5_rd0", 1'b1, 1'b1);
      do_read("t5_rd1", 1'b0, 1'b0);
      do_read("t5_rd2", 1'b0, 1'b0);
      rq.delete();
      do_read("t5_wrap", 1'b1, 1'b1);
      do_read("t5_after", 1'b1, 1'b0);
      check_eq("t5_addr_wrap", rq[0], 8'hEF);
      check_eq("t5_addr_next", rq[1], 8'h01);
      check_eq("t5_level", level, 2);

      // 6: contention, waiting read at level 1, flush in the middle
      do_flush();
      send_sym(4'b0101, 1'b0);
      repeat (5) tick();
      check_eq("t6_level3", level, 3);
      gq.delete();
      sym_in    = 4'b0011;
      mode      = 1'b1;
      sym_valid = 1'b1;
      rd_req    = 1'b1;
      tick();
      sym_valid = 1'b0;
      rd_req    = 1'b0;
      check_eq("t6_c1_rd_drive", {addr1, addr2, RdWr, DevEn}, {4'd0, 4'd1, 2'b00});
      tick();
      check_eq("t6_c2_out", {validOut, out0, out1}, 3'b110);
      check_eq("t6_c2_wr_drive", {addr1, WriteLine, RdWr, DevEn}, {4'd3, 3'b110});
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check_eq("t6_c3_rd_drive", {addr1, addr2, RdWr, DevEn}, {4'd2, 4'd3, 2'b00});
      tick();
      check_eq("t6_c4_out", {validOut, out0, out1}, 3'b111);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check_eq("t6_c5_level1", level, 1);
      tick();
      check_eq("t6_c6_level2", level, 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("t6_c7_level", level, 0);
      check_eq("t6_c7_novalid", validOut, 0);
      tick();
      check_eq("t6_c8_idle", {validOut, DevEn, level}, {2'b01, 5'd0});
      check_eq("t6_ngnt", (gq.size() >= 8) ? 1 : 0, 1);
      check_eq("t6_gnt_seq", {gq[0], gq[1], gq[2], gq[3], gq[4], gq[5], gq[6], gq[7]},
               {2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
